riscv_pipe_ctrl: RTL and testbench

//  Parametrised pipeline control for the riscv core: tracks DEPTH in-flight stages (valid/rd/rde) from issue to writeback.

---
 rtl/riscv_pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_pipe_ctrl
//   Pipeline control for the riscv core. It tracks DEPTH in-flight stages
//   (valid / rd / rde) from issue to writeback, stalls decode on RAW hazards,
//   squashes stages younger than a taken branch, and counts stall cycles.
//
//   Optional feature macro: RISCV_PIPE_FWD_EN
//     defined   - sources whose youngest producer sits at stage >= FWD_STAGE
//                 are forwarded instead of stalled.
//     undefined - every match stalls; fwd_* outputs are tied to 0.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   id_valid                decode holds a valid instruction
//   id_rs1/2, id_rs1e/2e    source indices and enables
//   id_rd, id_rde           destination index and enable
//   id_ready                1 = decode instruction issues this cycle
//   ex_taken                branch in entry BR_STAGE is taken
//   flush                   discard fetch/decode and stages 0..BR_STAGE-1
//   wb_valid/wb_rd/wb_rde   contents of the last entry (writeback)
//   stall_cnt               saturating stall-cycle counter
//   fwd_rs*_hit/_stg        forward request and source stage per operand
// ---------------------------------------------------------------------------

// Per-stage source comparator: one instance per tracked entry.
module riscv_pipe_match #(
  parameter int REG_WIDTH = 5
) (
  input  logic                 v,
  input  logic                 rde,
  input  logic [REG_WIDTH-1:0] rd,
  input  logic [REG_WIDTH-1:0] rs1,
  input  logic                 rs1e,
  input  logic [REG_WIDTH-1:0] rs2,
  input  logic                 rs2e,
  output logic                 hit1,
  output logic                 hit2
);
  // x0 is hardwired zero, so it never creates a dependency.
  assign hit1 = v & rde & rs1e & (rd == rs1) & (rs1 != '0);
  assign hit2 = v & rde & rs2e & (rd == rs2) & (rs2 != '0);
endmodule

module riscv_pipe_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int DEPTH     = 4,
  parameter int BR_STAGE  = 2,
  parameter int FWD_STAGE = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [REG_WIDTH-1:0]       id_rs1,
  input  logic [REG_WIDTH-1:0]       id_rs2,
  input  logic                       id_rs1e,
  input  logic                       id_rs2e,
  input  logic [REG_WIDTH-1:0]       id_rd,
  input  logic                       id_rde,
  output logic                       id_ready,
  input  logic                       ex_taken,
  output logic                       flush,
  output logic                       wb_valid,
  output logic [REG_WIDTH-1:0]       wb_rd,
  output logic                       wb_rde,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic                       fwd_rs1_hit,
  output logic                       fwd_rs2_hit,
  output logic [$clog2(DEPTH)-1:0]   fwd_rs1_stg,
  output logic [$clog2(DEPTH)-1:0]   fwd_rs2_stg
);
  localparam int SW = $clog2(DEPTH);

  typedef struct packed {
    logic                 v;
    logic [REG_WIDTH-1:0] rd;
    logic                 rde;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q;

  logic [DEPTH-1:0] m1, m2;
  logic [SW-1:0]    k1, k2;       // youngest matching stage per source
  logic             ok1, ok2;     // youngest match is in a forwardable stage
  logic             stall1, stall2;
  logic             hazard, issue;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    riscv_pipe_match #(.REG_WIDTH(REG_WIDTH)) u_match (
      .v    (ent_q[k].v),
      .rde  (ent_q[k].rde),
      .rd   (ent_q[k].rd),
      .rs1  (id_rs1),
      .rs1e (id_rs1e),
      .rs2  (id_rs2),
      .rs2e (id_rs2e),
      .hit1 (m1[k]),
      .hit2 (m2[k])
    );
  end

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    k1 = '0;
    k2 = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (m1[k]) k1 = SW'(k);
      if (m2[k]) k2 = SW'(k);
    end
  end

  assign ok1 = int'(k1) >= FWD_STAGE;
  assign ok2 = int'(k2) >= FWD_STAGE;

`ifdef RISCV_PIPE_FWD_EN
  assign stall1      = (|m1) & ~ok1;
  assign stall2      = (|m2) & ~ok2;
  assign fwd_rs1_hit = (|m1) & ok1;
  assign fwd_rs2_hit = (|m2) & ok2;
  assign fwd_rs1_stg = fwd_rs1_hit ? k1 : '0;
  assign fwd_rs2_stg = fwd_rs2_hit ? k2 : '0;
`else
  logic fwd_unused;
  assign fwd_unused  = ^{k1, k2, ok1, ok2};
  assign stall1      = |m1;
  assign stall2      = |m2;
  assign fwd_rs1_hit = 1'b0;
  assign fwd_rs2_hit = 1'b0;
  assign fwd_rs1_stg = '0;
  assign fwd_rs2_stg = '0;
`endif

  assign hazard   = stall1 | stall2;
  // A taken branch only counts when its entry actually holds an instruction.
  assign flush    = ex_taken & ent_q[BR_STAGE].v;
  assign id_ready = ~hazard & ~flush;
  assign issue    = id_valid & id_ready;

  assign wb_valid = ent_q[DEPTH-1].v;
  assign wb_rd    = ent_q[DEPTH-1].rd;
  assign wb_rde   = ent_q[DEPTH-1].rde;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q     <= '0;
      stall_cnt <= '0;
    end else begin
      // issue is already low during a flush, so entry 0 takes a bubble.
      ent_q[0] <= issue ? ent_t'{v: 1'b1, rd: id_rd, rde: id_rde} : '0;
      // Entries younger than the branch are squashed; the branch and
      // everything older keep advancing.
      for (int i = 1; i < DEPTH; i++)
        ent_q[i] <= (flush && i <= BR_STAGE) ? '0 : ent_q[i-1];
      if (id_valid && hazard && !flush && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_pipe_ctrl
//   Directed bench for riscv_pipe_ctrl at DEPTH=4, BR_STAGE=2, FWD_STAGE=2.
//   The counter is built 3 bits wide so saturation is reachable quickly.
//   Works in both builds (RISCV_PIPE_FWD_EN defined or not).
// ---------------------------------------------------------------------------
module tb_riscv_pipe_ctrl;
  localparam int RW   = 5;
  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int CMAX = 7;
`ifdef RISCV_PIPE_FWD_EN
  localparam int FWD = 1;
  localparam int RAW_STALLS = 2;
`else
  localparam int FWD = 0;
  localparam int RAW_STALLS = 4;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1e = 1'b0, id_rs2e = 1'b0, id_rde = 1'b0;
  logic          id_ready, ex_taken = 1'b0, flush;
  logic          wb_valid, wb_rde;
  logic [RW-1:0] wb_rd;
  logic [CW-1:0] stall_cnt;
  logic          fwd_rs1_hit, fwd_rs2_hit;
  logic [1:0]    fwd_rs1_stg, fwd_rs2_stg;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  riscv_pipe_ctrl #(
    .REG_WIDTH(RW), .DEPTH(D), .BR_STAGE(2), .FWD_STAGE(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1e(id_rs1e), .id_rs2e(id_rs2e),
    .id_rd(id_rd), .id_rde(id_rde), .id_ready(id_ready),
    .ex_taken(ex_taken), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rde(wb_rde),
    .stall_cnt(stall_cnt),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_stg(fwd_rs1_stg), .fwd_rs2_stg(fwd_rs2_stg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1e = 0; id_rs2e = 0;
    id_rd = 0; id_rde = 0; ex_taken = 0;
  endtask

  task automatic chk_rst_vals(input string tag);
    #1;
    chk({tag, "_ready"}, id_ready, 1);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_wbv"},   wb_valid, 0);
    chk({tag, "_wbrd"},  wb_rd, 0);
    chk({tag, "_wbrde"}, wb_rde, 0);
    chk({tag, "_cnt"},   stall_cnt, 0);
    chk({tag, "_fwd"},   {fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_stg, fwd_rs2_stg}, 0);
  endtask

  task automatic do_reset;
    idle; reset = 1; tick; tick; reset = 0;
    exp_cnt = 0;
  endtask

  task automatic issue_rd(input logic [RW-1:0] rd, input logic rde);
    idle; id_valid = 1; id_rd = rd; id_rde = rde;
    #1 chk("issue_rdy", id_ready, 1);
    tick;
  endtask

  // Producer writes r, consumer reads r on rs1 (or rs2); checks stall length,
  // forwarding outputs on the issuing cycle and the running stall count.
  task automatic raw_seq(input logic use2, input logic [RW-1:0] r);
    issue_rd(r, 1);
    for (int j = 0; j <= RAW_STALLS; j++) begin
      idle; id_valid = 1;
      if (use2) begin id_rs2 = r; id_rs2e = 1; end
      else      begin id_rs1 = r; id_rs1e = 1; end
      #1;
      chk("raw_ready", id_ready, (j == RAW_STALLS));
      if (j == RAW_STALLS) begin
        chk("raw_hit1", fwd_rs1_hit, use2 ? 0 : FWD);
        chk("raw_hit2", fwd_rs2_hit, use2 ? FWD : 0);
        chk("raw_stg",  use2 ? fwd_rs2_stg : fwd_rs1_stg, FWD ? 2 : 0);
      end
      tick;
    end
    exp_cnt = (exp_cnt + RAW_STALLS > CMAX) ? CMAX : exp_cnt + RAW_STALLS;
    idle; #1 chk("raw_cnt", stall_cnt, exp_cnt);
  endtask

  initial begin
    // 1: reset values, then four back-to-back issues drain in order
    do_reset;
    chk_rst_vals("rst0");
    for (int i = 0; i < 9; i++) begin
      idle; id_valid = (i < 4); id_rd = RW'(i + 1); id_rde = 1;
      #1;
      chk("t1_ready", id_ready, 1);
      chk("t1_wbv", wb_valid, (i >= 4 && i < 8));
      if (i >= 4 && i < 8) chk("t1_wbrd", wb_rd, i - 3);
      tick;
    end

    // 2: RAW stall on rs1, then rs2; counter saturates on repeats
    do_reset;
    raw_seq(0, 5);
    raw_seq(1, 6);
    raw_seq(0, 7);
    raw_seq(1, 5);

    // 3: x0 never hazards; disabled source never hazards
    do_reset;
    issue_rd(0, 1);
    idle; id_valid = 1; id_rs1 = 0; id_rs1e = 1; id_rs2 = 0; id_rs2e = 1;
    #1 chk("t3_x0_ready", id_ready, 1);
    tick;
    issue_rd(9, 1);
    idle; id_valid = 1; id_rs1 = 9; id_rs1e = 0;
    #1 chk("t3_dis_ready", id_ready, 1);
    tick;
    idle; #1 chk("t3_cnt", stall_cnt, 0);

    // 4: taken branch in entry 2 squashes rd 7/8
    do_reset;
    issue_rd(9, 1);
    issue_rd(7, 1);
    issue_rd(8, 1);
    idle; id_valid = 1; id_rd = 10; id_rde = 1; ex_taken = 1;
    #1 chk("t4_flush", flush, 1);
    chk("t4_ready", id_ready, 0);
    tick;
    idle; #1;
    chk("t4_flush_off", flush, 0);
    chk("t4_br_wbv", wb_valid, 1);
    chk("t4_br_wbrd", wb_rd, 9);
    tick;
    for (int i = 0; i < 3; i++) begin
      idle; ex_taken = (i == 0);  // entry 2 is empty now, so ignored
      #1;
      chk("t4_no_wb", wb_valid, 0);
      chk("t4_idle_flush", flush, 0);
      tick;
    end

    // 5: flush while consumer stalled, then reset mid-flow
    do_reset;
    issue_rd(9, 0);
    issue_rd(5, 1);
    idle; id_valid = 1; id_rs1 = 5; id_rs1e = 1;
    #1 chk("t5_stall", id_ready, 0);
    tick;
    ex_taken = 1;
    #1 chk("t5_flush", flush, 1);
    chk("t5_ready", id_ready, 0);
    tick;
    ex_taken = 0;
    #1 chk("t5_cnt", stall_cnt, 1);
    chk("t5_br_wbv", wb_valid, 1);
    chk("t5_br_wbrde", wb_rde, 0);
    reset = 1;
    tick;
    reset = 0; idle;
    chk_rst_vals("rst5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
